// File: rtl/scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_pkg
//  Description : Shared types and constants for the scan_mux_nto1 block.
//                - state_t     : controller states (IDLE, DIRECT, SCAN)
//                - MODE_DIRECT : mode value selecting direct (per-request) mode
//                - MODE_SCAN   : mode value selecting round-robin scan mode
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_mux_pkg
`default_nettype wire

// File: rtl/mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nto1
//  Description : Purely combinational N:1 multiplexer. Generalised
//                replacement for the fixed 4:1 gate-level mux.
//  Ports       : in_data  [NUM_CH*WIDTH] packed channels, channel k at
//                           in_data[k*WIDTH +: WIDTH]
//                idx      [IDX_W]        channel index
//                out_data [WIDTH]        selected channel, zero when
//                                        idx >= NUM_CH
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1
    import scan_mux_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int WIDTH  = 1,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [IDX_W-1:0]        idx,
    output logic [WIDTH-1:0]        out_data
);

    // Compare-and-select over every channel; an index that matches no
    // channel (out of range) falls through to the zero default.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_nto1
`default_nettype wire

// File: rtl/scan_mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module      : scan_mux_nto1
//  Description : Parametrised N:1 multiplexer with a registered,
//                valid/ready output. Direct mode selects one channel per
//                request; scan mode sweeps the channels round-robin.
//  Ports       : clk, rst_n (async, active-low)
//                in_data   channel k = in_data[k*WIDTH +: WIDTH]
//                mode      0 = direct, 1 = scan (sampled in IDLE)
//                sel / sel_valid / sel_ready  direct-mode request handshake
//                start     scan start pulse (sampled in IDLE)
//                stop      end a scan after the current beat
//                out_data / out_ch / out_err / out_valid / out_ready
//                          registered output beat and its handshake
//                busy      scan in progress
//                ch_mask   (SCAN_MUX_SKIP_MASK_EN only) channel enable mask,
//                          sampled at start; masked channels are skipped in
//                          scan and flagged as errors in direct mode
//  Options     : `define SCAN_MUX_SKIP_MASK_EN to add channel masking
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_mux_nto1
    import scan_mux_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int WIDTH      = 1,
    parameter int SEL_W      = $clog2(NUM_CH),
    parameter int CONTINUOUS = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_valid,
    output logic                    sel_ready,
    input  logic                    start,
    input  logic                    stop,
`ifdef SCAN_MUX_SKIP_MASK_EN
    input  logic [NUM_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err,
    output logic                    busy
);

    localparam logic [SEL_W:0] c_num_ch = (SEL_W+1)'(NUM_CH);

    state_t             r_state;
    logic [SEL_W-1:0]   r_cnt;
    logic               r_done;       // no further scan loads in this sweep
    logic               r_stop_pend;  // stop seen while the last beat stalls
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_ch;
    logic               r_out_valid;
    logic               r_out_err;
    logic               r_busy;

    logic               w_load_ok;
    logic               w_accept;
    logic               w_halt;
    logic               w_sel_oor;
    logic               w_sel_masked;
    logic [SEL_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_mux;
    logic [NUM_CH-1:0]  w_scan_mask;
    logic [NUM_CH-1:0]  w_start_mask;
    logic [SEL_W:0]     w_nxt;        // {found, index} of next enabled ch
    logic [SEL_W:0]     w_wrap;       // {found, index} of first enabled ch
    logic [SEL_W:0]     w_first;      // as w_wrap, using the mask at start

    // Lowest set bit of m at or above position lo; MSB of result = found.
    // Scanning downward lets the lowest qualifying bit win, so masked
    // channels are skipped in zero cycles.
    function automatic logic [SEL_W:0] f_find(input logic [NUM_CH-1:0] m,
                                              input int lo);
        logic [SEL_W:0] res;
        res = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if ((k >= lo) && m[k]) begin
                res = {1'b1, SEL_W'(k)};
            end
        end
        return res;
    endfunction

`ifdef SCAN_MUX_SKIP_MASK_EN
    logic [NUM_CH-1:0]  r_mask;
    logic               w_sel_bit;

    assign w_scan_mask  = r_mask;
    assign w_start_mask = ch_mask;

    always_comb begin
        w_sel_bit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_bit = ch_mask[k];
            end
        end
    end

    assign w_sel_masked = !w_sel_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if ((r_state == IDLE) && (mode == MODE_SCAN) && start) begin
            r_mask <= ch_mask;
        end
    end
`else
    localparam logic [NUM_CH-1:0] c_all_ch = '1;

    assign w_scan_mask  = c_all_ch;
    assign w_start_mask = c_all_ch;
    assign w_sel_masked = 1'b0;
`endif

    assign w_load_ok = !r_out_valid || out_ready;
    assign sel_ready = (r_state == DIRECT) && w_load_ok;
    assign w_accept  = sel_ready && sel_valid;
    assign w_sel_oor = ({1'b0, sel} >= c_num_ch);
    assign w_halt    = r_done || r_stop_pend || stop;
    assign w_idx     = (r_state == SCAN) ? r_cnt : sel;

    assign w_nxt   = f_find(w_scan_mask, int'(r_cnt) + 1);
    assign w_wrap  = f_find(w_scan_mask, 0);
    assign w_first = f_find(w_start_mask, 0);

    mux_nto1 #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .IDX_W  (SEL_W)
    ) u_mux (
        .in_data  (in_data),
        .idx      (w_idx),
        .out_data (w_mux)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    r_out_err   <= 1'b0;
                    r_stop_pend <= 1'b0;
                    if (mode == MODE_DIRECT) begin
                        r_state <= DIRECT;
                    end else if (start) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                        r_cnt   <= w_first[SEL_W-1:0];
                        // Empty mask: nothing to emit, leave after one cycle
                        r_done  <= !w_first[SEL_W];
                    end
                end

                DIRECT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_out_ch    <= sel;
                        if (w_sel_oor || w_sel_masked) begin
                            r_out_data <= '0;
                            r_out_err  <= 1'b1;
                        end else begin
                            r_out_data <= w_mux;
                            r_out_err  <= 1'b0;
                        end
                    end else begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_out_err   <= 1'b0;
                        end
                        // Leave only when no beat would be left stranded
                        if ((mode == MODE_SCAN) && w_load_ok) begin
                            r_state <= IDLE;
                        end
                    end
                end

                SCAN: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_halt) begin
                        // Stop wins over load_ok: finish the held beat only
                        if (w_load_ok) begin
                            r_out_valid <= 1'b0;
                            r_out_err   <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end else if (w_load_ok) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_mux;
                        r_out_ch    <= r_cnt;
                        r_out_err   <= 1'b0;
                        if (w_nxt[SEL_W]) begin
                            r_cnt <= w_nxt[SEL_W-1:0];
                        end else if (CONTINUOUS != 0) begin
                            r_cnt <= w_wrap[SEL_W-1:0];
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;
    assign busy      = r_busy;

endmodule : scan_mux_nto1
`default_nettype wire

// File: tb/tb_scan_mux_nto1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_scan_mux_nto1
//  Description : Self-checking bench for scan_mux_nto1. Four instances:
//                a: 16 ch x 1 bit, b: 12 ch x 8 bit (direct mode),
//                c: 4 ch x 8 bit one-shot scan, e: 4 ch x 8 bit continuous.
//                Control inputs are shared; each sequence checks the
//                instance it targets.
//  Options     : SCAN_MUX_SKIP_MASK_EN adds the channel-mask sequences
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_mux_nto1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mode, sel_valid, start, stop, out_ready;
    logic [3:0]  sel;
    logic [15:0] d1;
    logic [95:0] d2;
    logic [31:0] d34;

    logic        a_sready, a_data, a_valid, a_err, a_busy;
    logic [3:0]  a_ch;
    logic        b_sready, b_valid, b_err, b_busy;
    logic [7:0]  b_data;
    logic [3:0]  b_ch;
    logic        c_sready, c_valid, c_err, c_busy;
    logic [7:0]  c_data;
    logic [1:0]  c_ch;
    logic        e_sready, e_valid, e_err, e_busy;
    logic [7:0]  e_data;
    logic [1:0]  e_ch;

`ifdef SCAN_MUX_SKIP_MASK_EN
    logic [15:0] m1 = '1;
    logic [11:0] m2 = '1;
    logic [3:0]  m3 = '1;
    logic [3:0]  m4 = '1;
`endif

    scan_mux_nto1 #(.NUM_CH(16), .WIDTH(1), .CONTINUOUS(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(a_sready), .start(start), .stop(stop),
`ifdef SCAN_MUX_SKIP_MASK_EN
        .ch_mask(m1),
`endif
        .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid),
        .out_ready(out_ready), .out_err(a_err), .busy(a_busy));

    scan_mux_nto1 #(.NUM_CH(12), .WIDTH(8), .CONTINUOUS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(b_sready), .start(start), .stop(stop),
`ifdef SCAN_MUX_SKIP_MASK_EN
        .ch_mask(m2),
`endif
        .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid),
        .out_ready(out_ready), .out_err(b_err), .busy(b_busy));

    scan_mux_nto1 #(.NUM_CH(4), .WIDTH(8), .CONTINUOUS(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(d34), .mode(mode), .sel(sel[1:0]),
        .sel_valid(sel_valid), .sel_ready(c_sready), .start(start), .stop(stop),
`ifdef SCAN_MUX_SKIP_MASK_EN
        .ch_mask(m3),
`endif
        .out_data(c_data), .out_ch(c_ch), .out_valid(c_valid),
        .out_ready(out_ready), .out_err(c_err), .busy(c_busy));

    scan_mux_nto1 #(.NUM_CH(4), .WIDTH(8), .CONTINUOUS(1)) u_e (
        .clk(clk), .rst_n(rst_n), .in_data(d34), .mode(mode), .sel(sel[1:0]),
        .sel_valid(sel_valid), .sel_ready(e_sready), .start(start), .stop(stop),
`ifdef SCAN_MUX_SKIP_MASK_EN
        .ch_mask(m4),
`endif
        .out_data(e_data), .out_ch(e_ch), .out_valid(e_valid),
        .out_ready(out_ready), .out_err(e_err), .busy(e_busy));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
        logic        exp_data;
        logic [3:0]  exp_ch;
    } vec_t;

    vec_t vec [20];
    logic [7:0] scan_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        scan_exp[0] = 8'hAA; scan_exp[1] = 8'hBB; scan_exp[2] = 8'hCC; scan_exp[3] = 8'hDD;
        for (int k = 0; k < 16; k++) begin
            vec[k] = '{sel: 4'(k), data: 16'h1 << k, exp_data: 1'b1, exp_ch: 4'(k)};
        end
        // Inverted one-hot: selected channel is the only zero
        for (int j = 0; j < 4; j++) begin
            vec[16+j] = '{sel: 4'(j*5), data: ~(16'h1 << (j*5)), exp_data: 1'b0, exp_ch: 4'(j*5)};
        end

        rst_n = 1'b0; mode = 1'b0; sel = '0; sel_valid = 1'b0; start = 1'b0;
        stop = 1'b0; out_ready = 1'b1; d1 = '0;
        for (int k = 0; k < 12; k++) d2[k*8 +: 8] = 8'(8'h10 + k);
        d34 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

        // ---------------- reset state ----------------
        repeat (2) step();
        chk("rst a_valid", a_valid, 0); chk("rst a_data", a_data, 0);
        chk("rst a_ch", a_ch, 0);       chk("rst a_err", a_err, 0);
        chk("rst a_busy", a_busy, 0);   chk("rst a_sready", a_sready, 0);
        chk("rst b_valid", b_valid, 0); chk("rst b_data", b_data, 0);
        chk("rst b_err", b_err, 0);     chk("rst b_busy", b_busy, 0);
        chk("rst c_valid", c_valid, 0); chk("rst c_busy", c_busy, 0);
        chk("rst e_valid", e_valid, 0); chk("rst e_busy", e_busy, 0);
        rst_n = 1'b1;
        #1 chk("idle sel_ready", a_sready, 0);
        step();  // IDLE -> DIRECT

        // ---------------- direct mode table, 16 x 1 ----------------
        for (int i = 0; i < 20; i++) begin
            d1 = vec[i].data; sel = vec[i].sel; sel_valid = 1'b1;
            #1 chk("dir sel_ready", a_sready, 1);
            step();
            chk("dir valid", a_valid, 1);
            chk("dir data", a_data, vec[i].exp_data);
            chk("dir ch", a_ch, vec[i].exp_ch);
            chk("dir err", a_err, 0);
        end
        sel_valid = 1'b0;
        step();
        chk("dir drain valid", a_valid, 0);

        // ---------------- direct mode, 12 x 8, out of range ----------------
        sel = 4'd13; sel_valid = 1'b1;
        step();
        chk("oor valid", b_valid, 1); chk("oor err", b_err, 1);
        chk("oor data", b_data, 8'h00); chk("oor ch", b_ch, 13);
        sel = 4'd3;
        step();
        chk("in-range err", b_err, 0); chk("in-range data", b_data, 8'h13);
        sel = 4'd11;
        step();
        chk("last ch err", b_err, 0); chk("last ch data", b_data, 8'h1B);
        sel = 4'd12;
        step();
        chk("first oor err", b_err, 1); chk("first oor data", b_data, 8'h00);
        // output stall blocks new requests
        sel = 4'd5; out_ready = 1'b0;
        #1 chk("stall sel_ready", b_sready, 0);
        step();
        chk("stall hold ch", b_ch, 12); chk("stall hold err", b_err, 1);
        out_ready = 1'b1;
        step();
        chk("post-stall ch", b_ch, 5); chk("post-stall data", b_data, 8'h15);
        sel_valid = 1'b0; mode = 1'b1;
        step();  // DIRECT -> IDLE, beat drained
        chk("dir exit valid", b_valid, 0);

        // ---------------- one-shot and continuous scan ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        chk("scan busy", c_busy, 1); chk("scan first valid", c_valid, 0);
        chk("cont busy", e_busy, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("scan valid", c_valid, 1); chk("scan ch", c_ch, i);
            chk("scan data", c_data, scan_exp[i]); chk("scan err", c_err, 0);
            chk("scan sready", c_sready, 0);
            chk("cont ch", e_ch, i); chk("cont data", e_data, scan_exp[i]);
        end
        step();
        chk("scan end valid", c_valid, 0); chk("scan end busy", c_busy, 0);
        chk("cont wrap ch", e_ch, 0); chk("cont wrap data", e_data, 8'hAA);
        chk("cont wrap valid", e_valid, 1); chk("cont busy", e_busy, 1);
        step();
        chk("cont beat1 ch", e_ch, 1); chk("cont err", e_err, 0);
        chk("cont sready", e_sready, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop valid", e_valid, 0); chk("stop busy", e_busy, 0);
        step();
        chk("stop no beat2", e_valid, 0);
        chk("scan stays idle", c_busy, 0);

        // ---------------- scan with output stall on beat 2 ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        step(); chk("stl beat0 ch", c_ch, 0);
        step(); chk("stl beat1 ch", c_ch, 1);
        step(); chk("stl beat2 ch", c_ch, 2); chk("stl beat2 data", c_data, 8'hCC);
        out_ready = 1'b0;
        d34[23:16] = 8'h77;  // held beat must not follow the input
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl hold valid", c_valid, 1); chk("stl hold data", c_data, 8'hCC);
            chk("stl hold ch", c_ch, 2);
        end
        out_ready = 1'b1;
        step();
        chk("stl beat3 ch", c_ch, 3); chk("stl beat3 data", c_data, 8'hDD);
        step();
        chk("stl end valid", c_valid, 0); chk("stl end busy", c_busy, 0);
        d34[23:16] = 8'hCC;

        // ---------------- asynchronous reset mid-scan ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("pre-rst valid", c_valid, 1); chk("pre-rst ch", c_ch, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst c_valid", c_valid, 0); chk("arst c_data", c_data, 0);
        chk("arst c_ch", c_ch, 0);       chk("arst c_busy", c_busy, 0);
        chk("arst e_valid", e_valid, 0); chk("arst e_busy", e_busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post-rst valid", c_valid, 0); chk("post-rst busy", c_busy, 0);

`ifdef SCAN_MUX_SKIP_MASK_EN
        // ---------------- channel mask ----------------
        m3 = 4'b1010;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("mask busy", c_busy, 1); chk("mask first valid", c_valid, 0);
        step(); chk("mask beat ch1", c_ch, 1); chk("mask beat d1", c_data, 8'hBB);
        step(); chk("mask beat ch3", c_ch, 3); chk("mask beat d3", c_data, 8'hDD);
        step(); chk("mask end valid", c_valid, 0); chk("mask end busy", c_busy, 0);
        m3 = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty busy pulse", c_busy, 1); chk("empty valid", c_valid, 0);
        step();
        chk("empty busy end", c_busy, 0); chk("empty no beat", c_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_scan_mux_nto1
`default_nettype wire
